tb_service_cmd_mbox: RTL and testbench

Testbench-side command mailbox that sits directly upstream of the FC/LCC testbench service block. It snoops firmware writes to a dedicated mailbox address and queues them in a small FIFO. It then replays each command as single-cycle `tb_service_cmd_valid`/`tb_service_cmd` pulses, with a guaranteed idle gap between pulses and an optional repeat count. A sticky overflow flag and FIFO level are exported so the bench can detect dropped commands.

---
 rtl/tb_service_cmd_mbox_pkg.sv | 24 ++
 rtl/tb_service_cmd_fifo.sv | 73 +++++++
 rtl/tb_service_cmd_mbox.sv | 173 +++++++++++++++++
 tb/tb_tb_service_cmd_mbox.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tb_service_cmd_mbox_pkg.sv
// -----------------------------------------------------------------------------
// tb_service_cmd_mbox_pkg
// Shared types for the testbench service command mailbox: the issue FSM
// state encoding, the queued command entry and the NOP command code.
// -----------------------------------------------------------------------------
package tb_service_cmd_mbox_pkg;

    // Issue sequencer states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_GAP   = 2'd2
    } mbox_state_e;

    // One queued command: code plus extra repeat count (issued rpt+1 times).
    typedef struct packed {
        logic [7:0] cmd;
        logic [3:0] rpt;
    } mbox_entry_t;

    // Command code that is silently discarded at enqueue.
    localparam logic [7:0] MBOX_NOP = 8'h00;

endpackage

// File: rtl/tb_service_cmd_fifo.sv
// -----------------------------------------------------------------------------
// tb_service_cmd_fifo
// Synchronous FIFO of mbox_entry_t. A push while full is accepted when a pop
// happens on the same edge, so the level stays unchanged in that case.
//
// Ports:
//   clk, cptra_rst_b   clock, asynchronous active-low reset
//   i_push, i_entry    push strobe and entry to store
//   i_pop              pop strobe (ignored when empty)
//   o_head             entry at the head, valid while !o_empty
//   o_full, o_empty    occupancy flags
//   o_level            number of occupied entries
// -----------------------------------------------------------------------------
module tb_service_cmd_fifo
    import tb_service_cmd_mbox_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   cptra_rst_b,
    input  logic                   i_push,
    input  mbox_entry_t            i_entry,
    input  logic                   i_pop,
    output mbox_entry_t            o_head,
    output logic                   o_full,
    output logic                   o_empty,
    output logic [$clog2(DEPTH):0] o_level
);

    localparam int AW = $clog2(DEPTH);

    mbox_entry_t   r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_level;
    logic          w_push_ok;
    logic          w_pop_ok;

    assign o_full    = (r_level == (AW+1)'(DEPTH));
    assign o_empty   = (r_level == '0);
    assign w_pop_ok  = i_pop && !o_empty;
    // When full, the slot being written is the one being popped this edge.
    assign w_push_ok = i_push && (!o_full || w_pop_ok);
    assign o_head    = r_mem[r_rd_ptr];
    assign o_level   = r_level;

    // NOTE: storage carries no reset; the level counter alone decides which
    // slots hold live data, so clearing the array would only add reset fanout.
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= i_entry;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk or negedge cptra_rst_b) begin
        if (!cptra_rst_b) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

endmodule

// File: rtl/tb_service_cmd_mbox.sv
// -----------------------------------------------------------------------------
// tb_service_cmd_mbox
// Snoops firmware writes to CMD_ADDR, queues non-NOP commands and replays each
// as single-cycle tb_service_cmd_valid pulses, R+1 times per entry, with at
// least GAP idle cycles after every pulse. svc_busy stalls entry into ISSUE.
// A write to CLR_ADDR with data[0]=1 clears the sticky overflow flag.
//
// Ports:
//   clk, cptra_rst_b        clock, asynchronous active-low reset
//   wr_valid/addr/data/strb snooped bus write (data[7:0]=cmd, [11:8]=repeat)
//   svc_busy                downstream busy, blocks new pulses
//   tb_service_cmd_valid    one-cycle command pulse
//   tb_service_cmd          command code during the pulse, 8'h00 otherwise
//   fifo_level              queued entries
//   overflow                sticky drop indicator
// -----------------------------------------------------------------------------
module tb_service_cmd_mbox
    import tb_service_cmd_mbox_pkg::*;
#(
    parameter logic [31:0] CMD_ADDR = 32'h0,
    parameter logic [31:0] CLR_ADDR = 32'h4,
    parameter int          DEPTH    = 4,
    parameter int          GAP      = 2
) (
    input  logic                   clk,
    input  logic                   cptra_rst_b,
    input  logic                   wr_valid,
    input  logic [31:0]            wr_addr,
    input  logic [31:0]            wr_data,
    input  logic [3:0]             wr_strb,
    input  logic                   svc_busy,
    output logic                   tb_service_cmd_valid,
    output logic [7:0]             tb_service_cmd,
    output logic [$clog2(DEPTH):0] fifo_level,
    output logic                   overflow
);

    mbox_state_e r_state;
    mbox_state_e w_next_state;
    mbox_entry_t w_head;
    mbox_entry_t w_wr_entry;
    logic        w_empty;
    logic        w_full;
    logic        w_pop;
    logic        w_repeat;
    logic        w_enq;
    logic        w_clr;
    logic        w_drop;
    logic        w_valid_d;
    logic [7:0]  w_cmd_d;
    logic [7:0]  r_cur_cmd;
    logic [3:0]  r_cur_rpt;
    logic [3:0]  r_gap_cnt;
    logic        r_valid;
    logic [7:0]  r_cmd;
    logic        r_overflow;
    logic        w_unused;

    // ---------------- bus decode ----------------
    assign w_enq = wr_valid && (wr_addr == CMD_ADDR) && wr_strb[0]
                   && (wr_data[7:0] != MBOX_NOP);
    assign w_clr = wr_valid && (wr_addr == CLR_ADDR) && wr_strb[0] && wr_data[0];

    // Without the repeat byte enabled the entry is issued exactly once.
    assign w_wr_entry.cmd = wr_data[7:0];
    assign w_wr_entry.rpt = wr_strb[1] ? wr_data[11:8] : 4'd0;

    // A full FIFO only drops when the sequencer is not popping on this edge.
    assign w_drop = w_enq && w_full && !w_pop;

    // Bus bits with no function in the mailbox.
    assign w_unused = &{1'b0, wr_strb[3:2], wr_data[31:12]};

    tb_service_cmd_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .cptra_rst_b (cptra_rst_b),
        .i_push      (w_enq),
        .i_entry     (w_wr_entry),
        .i_pop       (w_pop),
        .o_head      (w_head),
        .o_full      (w_full),
        .o_empty     (w_empty),
        .o_level     (fifo_level)
    );

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge cptra_rst_b) begin
        if (!cptra_rst_b) r_state <= ST_IDLE;
        else              r_state <= w_next_state;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        // NOTE: every combinational output gets a default up front so no path
        // through the case leaves it unassigned and infers a latch.
        w_next_state = r_state;
        w_pop        = 1'b0;
        w_repeat     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!w_empty && !svc_busy) begin
                    w_pop        = 1'b1;
                    w_next_state = ST_ISSUE;
                end
            end
            ST_ISSUE: w_next_state = ST_GAP;
            ST_GAP: begin
                if (r_gap_cnt == '0) begin
                    if (r_cur_rpt != '0) begin
                        // Repeats of the current entry hold off the next one.
                        if (!svc_busy) begin
                            w_repeat     = 1'b1;
                            w_next_state = ST_ISSUE;
                        end
                    end else if (!w_empty && !svc_busy) begin
                        // Chaining straight into the next entry keeps queued
                        // commands exactly GAP+1 cycles apart.
                        w_pop        = 1'b1;
                        w_next_state = ST_ISSUE;
                    end else begin
                        w_next_state = ST_IDLE;
                    end
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // ---------------- FSM: outputs (registered below) ----------------
    always_comb begin
        w_valid_d = (w_next_state == ST_ISSUE);
        w_cmd_d   = MBOX_NOP;
        if (w_pop)         w_cmd_d = w_head.cmd;
        else if (w_repeat) w_cmd_d = r_cur_cmd;
    end

    // ---------------- datapath ----------------
    always_ff @(posedge clk or negedge cptra_rst_b) begin
        if (!cptra_rst_b) begin
            r_valid    <= 1'b0;
            r_cmd      <= MBOX_NOP;
            r_cur_cmd  <= MBOX_NOP;
            r_cur_rpt  <= '0;
            r_gap_cnt  <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_valid <= w_valid_d;
            r_cmd   <= w_cmd_d;

            if (w_pop) begin
                r_cur_cmd <= w_head.cmd;
                r_cur_rpt <= w_head.rpt;
            end else if (w_repeat) begin
                r_cur_rpt <= r_cur_rpt - 1'b1;
            end

            // Counter reaches zero after GAP low cycles following the pulse.
            if (r_state == ST_ISSUE)  r_gap_cnt <= 4'(GAP - 1);
            else if (r_gap_cnt != '0) r_gap_cnt <= r_gap_cnt - 1'b1;

            // A drop on the same edge as a clear keeps the flag set.
            if (w_drop)     r_overflow <= 1'b1;
            else if (w_clr) r_overflow <= 1'b0;
        end
    end

    assign tb_service_cmd_valid = r_valid;
    assign tb_service_cmd       = r_cmd;
    assign overflow             = r_overflow;

endmodule

// File: tb/tb_tb_service_cmd_mbox.sv
// -----------------------------------------------------------------------------
// tb_tb_service_cmd_mbox
// Self-checking bench for tb_service_cmd_mbox. A behavioural model (a queue
// of pending commands plus a count of low cycles since the last pulse)
// predicts the outputs every cycle; directed scenarios additionally pin pulse
// times and codes with hand-computed values.
// -----------------------------------------------------------------------------
module tb_tb_service_cmd_mbox;

    localparam logic [31:0] CMD_A   = 32'h0;
    localparam logic [31:0] CLR_A   = 32'h4;
    localparam int          DEPTH_P = 4;
    localparam int          GAP_P   = 2;

    logic        clk = 1'b0;
    logic        cptra_rst_b = 1'b0;
    logic        wr_valid = 1'b0;
    logic [31:0] wr_addr = '0;
    logic [31:0] wr_data = '0;
    logic [3:0]  wr_strb = '0;
    logic        svc_busy = 1'b0;
    logic        tb_service_cmd_valid;
    logic [7:0]  tb_service_cmd;
    logic [2:0]  fifo_level;
    logic        overflow;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    tb_service_cmd_mbox #(
        .CMD_ADDR (CMD_A),
        .CLR_ADDR (CLR_A),
        .DEPTH    (DEPTH_P),
        .GAP      (GAP_P)
    ) dut (
        .clk                  (clk),
        .cptra_rst_b          (cptra_rst_b),
        .wr_valid             (wr_valid),
        .wr_addr              (wr_addr),
        .wr_data              (wr_data),
        .wr_strb              (wr_strb),
        .svc_busy             (svc_busy),
        .tb_service_cmd_valid (tb_service_cmd_valid),
        .tb_service_cmd       (tb_service_cmd),
        .fifo_level           (fifo_level),
        .overflow             (overflow)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (act !== exp) begin
            n_errors = n_errors + 1;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        logic [7:0] cmd;
        int         rpt;
    } m_entry_t;

    m_entry_t   mq[$];
    int         m_low = 1000;     // low output cycles since the last pulse
    int         m_rpt_left = 0;   // pulses still owed by the active entry
    logic [7:0] m_cmd = 8'h00;
    logic       m_exp_valid = 1'b0;
    logic [7:0] m_exp_cmd = 8'h00;
    int         m_exp_level = 0;
    logic       m_exp_ovf = 1'b0;

    task automatic model_reset();
        mq.delete();
        m_low       = 1000;
        m_rpt_left  = 0;
        m_cmd       = 8'h00;
        m_exp_valid = 1'b0;
        m_exp_cmd   = 8'h00;
        m_exp_level = 0;
        m_exp_ovf   = 1'b0;
    endtask

    task automatic model_step();
        bit       fire;
        bit       enq;
        bit       clr;
        bit       drop;
        m_entry_t e;
        // Account for the cycle that is ending at this edge.
        if (m_exp_valid) m_low = 0;
        else if (m_low < 1000) m_low = m_low + 1;
        fire = 1'b0;
        if (m_low >= GAP_P && !svc_busy) begin
            if (m_rpt_left > 0) begin
                m_rpt_left = m_rpt_left - 1;
                fire = 1'b1;
            end else if (mq.size() != 0) begin
                e = mq.pop_front();
                m_cmd = e.cmd;
                m_rpt_left = e.rpt;
                fire = 1'b1;
            end
        end
        enq  = wr_valid && wr_addr == CMD_A && wr_strb[0] && wr_data[7:0] != 8'h00;
        clr  = wr_valid && wr_addr == CLR_A && wr_strb[0] && wr_data[0];
        drop = 1'b0;
        if (enq) begin
            e.cmd = wr_data[7:0];
            e.rpt = wr_strb[1] ? int'(wr_data[11:8]) : 0;
            if (mq.size() < DEPTH_P) mq.push_back(e);
            else drop = 1'b1;
        end
        if (drop) m_exp_ovf = 1'b1;
        else if (clr) m_exp_ovf = 1'b0;
        m_exp_valid = fire;
        m_exp_cmd   = fire ? m_cmd : 8'h00;
        m_exp_level = mq.size();
    endtask

    always @(posedge clk or negedge cptra_rst_b) begin
        if (!cptra_rst_b) model_reset();
        else              model_step();
    end

    // ---------------- compare process and pulse log ----------------
    typedef struct {
        int         cyc;
        logic [7:0] cmd;
    } pulse_t;

    pulse_t plog[$];

    always @(negedge clk) begin
        check("valid", 32'(tb_service_cmd_valid), 32'(m_exp_valid));
        check("cmd",   32'(tb_service_cmd),       32'(m_exp_cmd));
        check("level", 32'(fifo_level),           32'(m_exp_level));
        check("ovf",   32'(overflow),             32'(m_exp_ovf));
        if (tb_service_cmd_valid === 1'b1) plog.push_back('{cyc, tb_service_cmd});
    end

    // ---------------- stimulus helpers ----------------
    task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        wr_valid = 1'b1;
        wr_addr  = a;
        wr_data  = d;
        wr_strb  = s;
        @(posedge clk);
        #1;
        wr_valid = 1'b0;
        wr_addr  = '0;
        wr_data  = '0;
        wr_strb  = '0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_pulse(input string name, input int idx, input int cyc_exp,
                                input logic [7:0] cmd_exp);
        if (idx < plog.size()) begin
            check({name, "_cyc"}, 32'(plog[idx].cyc), 32'(cyc_exp));
            check({name, "_cmd"}, 32'(plog[idx].cmd), 32'(cmd_exp));
        end else begin
            check({name, "_present"}, 32'(plog.size()), 32'(idx + 1));
        end
    endtask

    // ---------------- directed scenarios ----------------
    initial begin : stim
        int n;
        int b;

        repeat (3) @(posedge clk);
        #1;
        cptra_rst_b = 1'b1;
        check("rst_valid", 32'(tb_service_cmd_valid), 32'h0);
        check("rst_cmd",   32'(tb_service_cmd),       32'h0);
        check("rst_level", 32'(fifo_level),           32'h0);
        check("rst_ovf",   32'(overflow),             32'h0);
        idle(2);

        // Single command: pulse in the cycle after edge N+1, queue drains.
        plog.delete();
        bus_write(CMD_A, 32'h0000_0021, 4'b0011);
        n = cyc;
        idle(8);
        check("single_count", 32'(plog.size()), 32'd1);
        expect_pulse("single", 0, n + 1, 8'h21);
        check("single_level", 32'(fifo_level), 32'd0);

        // Repeat count 2: three pulses, GAP+1 cycles apart.
        plog.delete();
        bus_write(CMD_A, 32'h0000_0235, 4'b0011);
        n = cyc;
        idle(12);
        check("rpt_count", 32'(plog.size()), 32'd3);
        for (int i = 0; i < 3; i++) expect_pulse("rpt", i, n + 1 + 3 * i, 8'h35);

        // Overflow: six writes while busy, four survive in order.
        plog.delete();
        svc_busy = 1'b1;
        for (int i = 0; i < 6; i++) begin
            bus_write(CMD_A, 32'h41 + 32'(i), 4'b0001);
            check("sat_level", 32'(fifo_level), (i < 4) ? 32'(i + 1) : 32'd4);
            check("sat_ovf",   32'(overflow),   (i < 4) ? 32'd0 : 32'd1);
        end
        svc_busy = 1'b0;
        b = cyc + 1;
        idle(14);
        check("ovf_count", 32'(plog.size()), 32'd4);
        for (int i = 0; i < 4; i++) expect_pulse("ovf_order", i, b + 3 * i, 8'h41 + 8'(i));

        // Clear decode: data[0]=0 and strb[0]=0 are ignored, a proper clear works.
        bus_write(CLR_A, 32'h0000_0000, 4'b0001);
        check("clr_d0", 32'(overflow), 32'd1);
        bus_write(CLR_A, 32'h0000_0001, 4'b1110);
        check("clr_strb", 32'(overflow), 32'd1);
        bus_write(CLR_A, 32'h0000_0001, 4'b0001);
        check("clr_ok", 32'(overflow), 32'd0);

        // Push into a full FIFO on the pop edge is accepted, level unchanged.
        plog.delete();
        svc_busy = 1'b1;
        for (int i = 0; i < 4; i++) bus_write(CMD_A, 32'h51 + 32'(i), 4'b0001);
        check("full_level", 32'(fifo_level), 32'd4);
        svc_busy = 1'b0;
        bus_write(CMD_A, 32'h0000_0055, 4'b0001);
        check("full_pop_level", 32'(fifo_level), 32'd4);
        check("full_pop_ovf",   32'(overflow),   32'd0);
        idle(18);
        check("full_pop_count", 32'(plog.size()), 32'd5);
        for (int i = 0; i < 5; i++)
            if (i < plog.size()) check("full_pop_order", 32'(plog[i].cmd), 32'h51 + 32'(i));

        // Busy held while a repeat is owed: pulse fires right after busy drops.
        plog.delete();
        bus_write(CMD_A, 32'h0000_0155, 4'b0011);
        n = cyc;
        idle(1);
        svc_busy = 1'b1;
        idle(6);
        check("busy_hold_count", 32'(plog.size()), 32'd1);
        svc_busy = 1'b0;
        b = cyc + 1;
        idle(6);
        expect_pulse("busy_first", 0, n + 1, 8'h55);
        expect_pulse("busy_second", 1, b, 8'h55);

        // NOP, repeat byte disabled, wrong address, missing strb[0].
        plog.delete();
        bus_write(CMD_A, 32'h0000_0500, 4'b0011);
        bus_write(CMD_A, 32'hFFFF_F377, 4'b1101);
        bus_write(32'h8, 32'h0000_0088, 4'b1111);
        bus_write(CMD_A, 32'h0000_0099, 4'b1110);
        idle(8);
        check("decode_count", 32'(plog.size()), 32'd1);
        if (plog.size() > 0) check("decode_cmd", 32'(plog[0].cmd), 32'h77);
        check("decode_ovf", 32'(overflow), 32'd0);

        // Reset during GAP with two entries queued drops everything.
        plog.delete();
        bus_write(CMD_A, 32'h0000_0061, 4'b0001);
        bus_write(CMD_A, 32'h0000_0062, 4'b0001);
        bus_write(CMD_A, 32'h0000_0063, 4'b0001);
        check("pre_rst_level", 32'(fifo_level), 32'd2);
        cptra_rst_b = 1'b0;
        #1;
        check("mid_rst_valid", 32'(tb_service_cmd_valid), 32'd0);
        check("mid_rst_level", 32'(fifo_level),           32'd0);
        idle(2);
        cptra_rst_b = 1'b1;
        idle(20);
        check("post_rst_count", 32'(plog.size()), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
